instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 The module SHALL have parameter INSTR_W, default 16: instruction width in bits (opcode in bits [INSTR_W-1:INSTR_W-4]).
REQ-003 The module SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 The module SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 The module SHALL have port mem_req, output, 1: instruction memory read request.
REQ-006 The module SHALL have port mem_addr, output, 16: word address of the request (the current PC).
REQ-007 The module SHALL have port mem_ack, input, 1: memory has returned mem_rdata this cycle.
REQ-008 The module SHALL have port mem_rdata, input, INSTR_W: instruction word, valid only when mem_ack=1.
REQ-009 The module SHALL have port issue_valid, output, 1: instr/op/pc_out hold a fetched instruction.
REQ-010 The module SHALL have port issue_ready, input, 1: the decoder (Main_Control stage) accepts the instruction.
REQ-011 The module SHALL have port instr, output, INSTR_W: registered instruction word.
REQ-012 The module SHALL have port op, output, 4: opcode field of instr, driven to the Main_Control op input.
REQ-013 The module SHALL have port pc_out, output, 16: address the issued instruction was fetched from.
REQ-014 The module SHALL have port redirect_valid, input, 1: taken branch (BEQ/BNE resolved); the PC is replaced.
REQ-015 The module SHALL have port redirect_pc, input, 16: branch target, valid when redirect_valid=1.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, DISCARD and ISSUE.
REQ-017 IDLE SHALL last exactly one cycle after reset release, with mem_req=0, then SHALL go to FETCH.
REQ-018 In FETCH and DISCARD the module SHALL drive mem_req=1, and mem_addr SHALL remain stable until mem_ack.
REQ-019 On FETCH with mem_ack=1 and no redirect, mem_rdata SHALL be captured into instr and the FSM SHALL go to ISSUE; issue_valid=1 the next cycle (fetch latency = ack cycle + 1).
REQ-020 In ISSUE, issue_valid, instr, op and pc_out SHALL stay stable until issue_valid && issue_ready.
REQ-021 On the issue handshake the PC SHALL become PC+1, the FSM SHALL go to FETCH, and mem_req SHALL be high the next cycle.
REQ-022 PC arithmetic SHALL be modulo 2^16, so 16'hFFFF+1 wraps to 16'h0000 with no flag.
REQ-023 A redirect in FETCH without mem_ack SHALL load the PC with redirect_pc and move the FSM to DISCARD, keeping the old mem_addr until mem_ack.
REQ-024 On mem_ack in DISCARD, the data SHALL be dropped and the FSM SHALL go to FETCH at the new PC.
REQ-025 A redirect in FETCH coinciding with mem_ack SHALL drop the data and send the FSM to FETCH with PC=redirect_pc.
REQ-026 A redirect in ISSUE SHALL drop the held instruction (issue_valid=0 next cycle) and send the FSM to FETCH with PC=redirect_pc.
REQ-027 If a redirect coincides with the issue handshake, the instruction SHALL count as issued and the PC SHALL become redirect_pc, not PC+1.
REQ-028 A redirect in DISCARD SHALL overwrite the PC with the latest redirect_pc.
REQ-029 A redirect in IDLE SHALL load the PC with redirect_pc.
REQ-030 op SHALL always equal instr[INSTR_W-1:INSTR_W-4].

Reset
REQ-031 On rst the module SHALL set state=IDLE, PC=RESET_PC, mem_req=0, mem_addr=RESET_PC, issue_valid=0, instr=0, op=4'b0000 and pc_out=0.
REQ-032 Reset asserted mid-request SHALL abandon the request, and any mem_ack arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-033 When FETCH_ICOUNT_EN is defined, the module SHALL add output icount, 16 bits, reset to 0, incremented by 1 on every issue handshake and wrapping at 16'hFFFF→0.
REQ-034 When FETCH_ICOUNT_EN is undefined, the icount port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 The shared package minimips_pkg SHALL hold the opcode constants OP_RTYPE=4'b0000, OP_ITYPE=4'b0001, OP_BEQ=4'b0101, OP_LW=4'b1000 and OP_SW=4'b1001, the fetch-state enum and the instruction field positions.
REQ-036 The PC register with its increment/redirect mux SHALL be the single sub-module minimips_pc_reg, and the FSM SHALL stay in instr_fetch_unit.

Verification
REQ-037 The bench SHALL check sequential fetch: memory words 0x0123, 0x1456, 0x5001 at addresses 0-2, 1-cycle ack, issue_ready=1 → op sequence 0000, 0001, 0101 with pc_out 0, 1, 2.
REQ-038 The bench SHALL check backpressure: issue_ready=0 for 5 cycles while holding 0x8ABC → instr, op=1000 and pc_out stable; mem_req=0 throughout; PC advances only after ready=1.
REQ-039 The bench SHALL check redirect in DISCARD: redirect_pc=0x0040 in FETCH with ack delayed 3 cycles → mem_addr stays old until ack, data dropped, next mem_addr=0x0040, and the next issue has pc_out=0x0040.
REQ-040 The bench SHALL check redirect with the issue handshake: redirect_pc=0x0010 in the same cycle as the handshake at PC 0x0005 → that instruction is issued, the next mem_addr=0x0010, and icount increments once (with FETCH_ICOUNT_EN).
REQ-041 The bench SHALL check wrap: RESET_PC=16'hFFFF and one issue → next mem_addr=16'h0000.
REQ-042 The bench SHALL check mid-request reset: rst pulsed while mem_req=1 → all outputs at their reset values, then after one IDLE cycle mem_addr=RESET_PC.

Source files
------------

// File: rtl/minimips_pkg.sv
// rtl/minimips_pkg.sv - shared opcodes, fetch-state enum and instruction field positions
// Contents: OP_* opcode constants, fetch_state_e, opcode field helpers, PC width.
package minimips_pkg;

    localparam int PC_W     = 16;
    localparam int OPCODE_W = 4;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ITYPE = 4'b0001;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        ISSUE   = 2'd3
    } fetch_state_e;

    // Opcode occupies the top OPCODE_W bits of the instruction word.
    function automatic int opcode_msb(input int instr_w);
        return instr_w - 1;
    endfunction

    function automatic int opcode_lsb(input int instr_w);
        return instr_w - OPCODE_W;
    endfunction

endpackage

// File: rtl/minimips_pc_reg.sv
// rtl/minimips_pc_reg.sv - program counter register with increment/redirect mux
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   inc_i       : advance PC by one (issue handshake)
//   load_i      : load load_pc_i (redirect); wins over inc_i
//   load_pc_i   : redirect target
//   pc_o        : current PC
//   pc_next_o   : PC value after the coming clock edge
module minimips_pc_reg
    import minimips_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        load_i,
    input  logic [15:0] load_pc_i,
    output logic [15:0] pc_o,
    output logic [15:0] pc_next_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // 16-bit add wraps 16'hFFFF to 16'h0000 naturally.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch FSM with branch redirect and issue handshake
// Optional feature macro: FETCH_ICOUNT_EN (adds icount issued-instruction counter).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   mem_req, mem_addr         : instruction memory read request and word address
//   mem_ack, mem_rdata        : memory response
//   issue_valid, issue_ready  : handshake towards the decoder
//   instr, op, pc_out         : issued instruction, its opcode and fetch address
//   redirect_valid/_pc        : taken-branch PC replacement
//   icount (FETCH_ICOUNT_EN)  : number of issue handshakes, wraps at 16 bits
module instr_fetch_unit
    import minimips_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [15:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         op,
    output logic [15:0]        pc_out,
    input  logic               redirect_valid,
    input  logic [15:0]        redirect_pc
`ifdef FETCH_ICOUNT_EN
    ,
    output logic [15:0]        icount
`endif
);

    localparam int OP_MSB = opcode_msb(INSTR_W);
    localparam int OP_LSB = opcode_lsb(INSTR_W);

    fetch_state_e state_q, state_d;

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [15:0]        pc_out_q, pc_out_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [15:0]        pc;
    logic [15:0]        pc_next;
    logic               handshake;

    assign handshake = (state_q == ISSUE) && issue_ready;

    minimips_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (handshake),
        .load_i    (redirect_valid),
        .load_pc_i (redirect_pc),
        .pc_o      (pc),
        .pc_next_o (pc_next)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;

        case (state_q)
            IDLE: begin
                // mem_ack here belongs to a request abandoned by reset.
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    // With ack the stale word is dropped now; without ack
                    // the in-flight read must still be drained.
                    state_d = mem_ack ? FETCH : DISCARD;
                end else if (mem_ack) begin
                    state_d  = ISSUE;
                    instr_d  = mem_rdata;
                    pc_out_d = mem_addr_q;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    state_d = FETCH;
                end
            end
            ISSUE: begin
                if (handshake || redirect_valid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // The request address is frozen while an outstanding read drains;
        // otherwise it tracks the PC.
        mem_addr_d = (state_d == DISCARD) ? mem_addr_q : pc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            pc_out_q   <= '0;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            mem_addr_q <= mem_addr_d;
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic [15:0] icount_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icount_q <= '0;
        end else if (handshake) begin
            icount_q <= icount_q + 16'd1;
        end
    end

    assign icount = icount_q;
`endif

    assign mem_req     = (state_q == FETCH) || (state_q == DISCARD);
    assign mem_addr    = mem_addr_q;
    assign issue_valid = (state_q == ISSUE);
    assign instr       = instr_q;
    assign op          = instr_q[OP_MSB:OP_LSB];
    assign pc_out      = pc_out_q;

    // pc mirrors mem_addr except while draining; kept visible for debug.
    logic unused_pc;
    assign unused_pc = ^pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        issue_valid;
    logic        issue_ready = 1'b1;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [15:0] pc_out;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] icount;

    logic        w_rst = 1'b1;
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_ack = 1'b0;
    logic [15:0] w_rdata = 16'h0000;
    logic        w_valid;
    logic [15:0] w_instr;
    logic [3:0]  w_op;
    logic [15:0] w_pc_out;
    logic [15:0] w_icount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

`ifdef FETCH_ICOUNT_EN
    instr_fetch_unit #(.RESET_PC(16'h0000), .INSTR_W(16)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .instr(instr), .op(op), .pc_out(pc_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .icount(icount)
    );
    instr_fetch_unit #(.RESET_PC(16'hFFFF), .INSTR_W(16)) dut_wrap (
        .clk(clk), .rst(w_rst), .mem_req(w_req), .mem_addr(w_addr),
        .mem_ack(w_ack), .mem_rdata(w_rdata), .issue_valid(w_valid),
        .issue_ready(1'b1), .instr(w_instr), .op(w_op), .pc_out(w_pc_out),
        .redirect_valid(1'b0), .redirect_pc(16'h0000), .icount(w_icount)
    );
`else
    assign icount   = 16'h0000;
    assign w_icount = 16'h0000;
    instr_fetch_unit #(.RESET_PC(16'h0000), .INSTR_W(16)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .instr(instr), .op(op), .pc_out(pc_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );
    instr_fetch_unit #(.RESET_PC(16'hFFFF), .INSTR_W(16)) dut_wrap (
        .clk(clk), .rst(w_rst), .mem_req(w_req), .mem_addr(w_addr),
        .mem_ack(w_ack), .mem_rdata(w_rdata), .issue_valid(w_valid),
        .issue_ready(1'b1), .instr(w_instr), .op(w_op), .pc_out(w_pc_out),
        .redirect_valid(1'b0), .redirect_pc(16'h0000)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({mem_req, mem_addr, issue_valid, instr, op, pc_out} !== {1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b addr=%h valid=%0b instr=%h op=%h pc_out=%h, want 0/0000/0/0000/0/0000",
                     mem_req, mem_addr, issue_valid, instr, op, pc_out);
        end
        checks++;
        if ({w_req, w_addr, w_valid} !== {1'b0, 16'hFFFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_wrap_dut: req=%0b addr=%h valid=%0b, want 0/ffff/0", w_req, w_addr, w_valid);
        end
`ifdef FETCH_ICOUNT_EN
        checks++;
        if (icount !== 16'h0000) begin
            errors++;
            $display("FAIL reset_icount: got %h want 0000", icount);
        end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle_req: got %0b want 0", mem_req);
        end
        tick();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL first_fetch: req=%0b addr=%h, want 1/0000", mem_req, mem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        logic [3:0]  ops [3];
        words = '{16'h0123, 16'h1456, 16'h5001};
        ops   = '{4'b0000, 4'b0001, 4'b0101};
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, 16'(i)}) begin
                errors++;
                $display("FAIL seq_req[%0d]: req=%0b addr=%h, want 1/%h", i, mem_req, mem_addr, 16'(i));
            end
            mem_ack = 1'b1;
            mem_rdata = words[i];
            tick();
            mem_ack = 1'b0;
            checks++;
            if ({issue_valid, instr, op, pc_out} !== {1'b1, words[i], ops[i], 16'(i)}) begin
                errors++;
                $display("FAIL seq_issue[%0d]: valid=%0b instr=%h op=%h pc_out=%h, want 1/%h/%h/%h",
                         i, issue_valid, instr, op, pc_out, words[i], ops[i], 16'(i));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0003}) begin
            errors++;
            $display("FAIL bp_req: req=%0b addr=%h, want 1/0003", mem_req, mem_addr);
        end
        issue_ready = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'h8ABC;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({issue_valid, instr, op, pc_out, mem_req, mem_addr} !== {1'b1, 16'h8ABC, 4'b1000, 16'h0003, 1'b0, 16'h0003}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%0b instr=%h op=%h pc_out=%h req=%0b addr=%h, want 1/8abc/8/0003/0/0003",
                         k, issue_valid, instr, op, pc_out, mem_req, mem_addr);
            end
            tick();
        end
        issue_ready = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_addr, issue_valid} !== {1'b1, 16'h0004, 1'b0}) begin
            errors++;
            $display("FAIL bp_release: req=%0b addr=%h valid=%0b, want 1/0004/0", mem_req, mem_addr, issue_valid);
        end
    endtask

    task automatic test_redirect_discard();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({mem_req, mem_addr, issue_valid} !== {1'b1, 16'h0004, 1'b0}) begin
                errors++;
                $display("FAIL discard_hold[%0d]: req=%0b addr=%h valid=%0b, want 1/0004/0", k, mem_req, mem_addr, issue_valid);
            end
            tick();
        end
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, mem_addr, issue_valid} !== {1'b1, 16'h0040, 1'b0}) begin
            errors++;
            $display("FAIL discard_drop: req=%0b addr=%h valid=%0b, want 1/0040/0", mem_req, mem_addr, issue_valid);
        end
        mem_ack = 1'b1;
        mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({issue_valid, instr, pc_out} !== {1'b1, 16'h1111, 16'h0040}) begin
            errors++;
            $display("FAIL discard_next_issue: valid=%0b instr=%h pc_out=%h, want 1/1111/0040", issue_valid, instr, pc_out);
        end
        tick();
        checks++;
        if (mem_addr !== 16'h0041) begin
            errors++;
            $display("FAIL discard_advance: addr=%h want 0041", mem_addr);
        end
    endtask

    task automatic test_redirect_handshake();
        // Redirect coinciding with ack in FETCH: data dropped, fetch restarts at target.
        redirect_valid = 1'b1;
        redirect_pc = 16'h0005;
        mem_ack = 1'b1;
        mem_rdata = 16'h2222;
        tick();
        redirect_valid = 1'b0;
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, mem_addr, issue_valid} !== {1'b1, 16'h0005, 1'b0}) begin
            errors++;
            $display("FAIL fetch_ack_redirect: req=%0b addr=%h valid=%0b, want 1/0005/0", mem_req, mem_addr, issue_valid);
        end
        issue_ready = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'h9005;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({issue_valid, op, pc_out} !== {1'b1, 4'b1001, 16'h0005}) begin
            errors++;
            $display("FAIL hs_before: valid=%0b op=%h pc_out=%h, want 1/9/0005", issue_valid, op, pc_out);
        end
`ifdef FETCH_ICOUNT_EN
        checks++;
        if (icount !== 16'd5) begin
            errors++;
            $display("FAIL hs_icount_before: got %0d want 5", icount);
        end
`endif
        issue_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({mem_req, mem_addr, issue_valid} !== {1'b1, 16'h0010, 1'b0}) begin
            errors++;
            $display("FAIL hs_redirect: req=%0b addr=%h valid=%0b, want 1/0010/0", mem_req, mem_addr, issue_valid);
        end
`ifdef FETCH_ICOUNT_EN
        checks++;
        if (icount !== 16'd6) begin
            errors++;
            $display("FAIL hs_icount_after: got %0d want 6", icount);
        end
`endif
    endtask

    task automatic test_redirect_issue();
        issue_ready = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'h3333;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({issue_valid, pc_out} !== {1'b1, 16'h0010}) begin
            errors++;
            $display("FAIL issue_hold: valid=%0b pc_out=%h, want 1/0010", issue_valid, pc_out);
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({issue_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 16'h0020}) begin
            errors++;
            $display("FAIL issue_redirect: valid=%0b req=%0b addr=%h, want 0/1/0020", issue_valid, mem_req, mem_addr);
        end
`ifdef FETCH_ICOUNT_EN
        checks++;
        if (icount !== 16'd6) begin
            errors++;
            $display("FAIL issue_redirect_icount: got %0d want 6", icount);
        end
`endif
        issue_ready = 1'b1;
    endtask

    task automatic test_mid_reset();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: req=%0b want 1", mem_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, issue_valid, instr, op, pc_out} !== {1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 16'h0000}) begin
            errors++;
            $display("FAIL midrst_outputs: req=%0b addr=%h valid=%0b instr=%h op=%h pc_out=%h, want 0/0000/0/0000/0/0000",
                     mem_req, mem_addr, issue_valid, instr, op, pc_out);
        end
`ifdef FETCH_ICOUNT_EN
        checks++;
        if (icount !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_icount: got %h want 0000", icount);
        end
`endif
        mem_ack = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: req=%0b want 0", mem_req);
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, mem_addr, issue_valid, instr} !== {1'b1, 16'h0000, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL midrst_refetch: req=%0b addr=%h valid=%0b instr=%h, want 1/0000/0/0000",
                     mem_req, mem_addr, issue_valid, instr);
        end
    endtask

    task automatic test_wrap();
        w_rst = 1'b0;
        tick();
        checks++;
        if ({w_req, w_addr} !== {1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL wrap_fetch: req=%0b addr=%h, want 1/ffff", w_req, w_addr);
        end
        w_ack = 1'b1;
        w_rdata = 16'h1234;
        tick();
        w_ack = 1'b0;
        checks++;
        if ({w_valid, w_op, w_pc_out} !== {1'b1, 4'h1, 16'hFFFF}) begin
            errors++;
            $display("FAIL wrap_issue: valid=%0b op=%h pc_out=%h, want 1/1/ffff", w_valid, w_op, w_pc_out);
        end
        tick();
        checks++;
        if ({w_req, w_addr} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_next: req=%0b addr=%h, want 1/0000", w_req, w_addr);
        end
`ifdef FETCH_ICOUNT_EN
        checks++;
        if (w_icount !== 16'd1) begin
            errors++;
            $display("FAIL wrap_icount: got %0d want 1", w_icount);
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_discard();
        test_redirect_handshake();
        test_redirect_issue();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
